// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states, bus widths and pprot bit positions.
// Imported by the APB4 bridge and by the reusable timeout counter.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // A zero-cycle timeout still needs a one-bit counter to keep the port list legal.
    function automatic int timeoutCntWidth(input int cycles);
        return (cycles == 0) ? 1 : $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Wait-state counter with synchronous clear and a terminal-count flag.
// TIMEOUT_CYCLES = 0 disables the terminal flag entirely.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int CNT_W = timeoutCntWidth(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign terminal_o = (TIMEOUT_CYCLES != 0) && (count_q == LAST_COUNT);

    // Saturate at the terminal value so a stalled owner never sees the flag wrap away.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 requester: turns a valid/ready command stream into single SETUP/ACCESS transfers
// and returns read data plus error/timeout status on a valid/ready response stream.
module apb4_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDRWIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDRWIDTH-1:0]  cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    input  logic [APB_STRB_W-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDRWIDTH-1:0]  paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_STRB_W-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_state_e state_q;
    apb_state_e state_d;

    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDRWIDTH-1:0]  paddr_q,       paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q,      pwdata_d;
    logic [APB_STRB_W-1:0] pstrb_q,       pstrb_d;
    logic [2:0]            pprot_q,       pprot_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic cmd_accept;
    logic apb_complete;
    logic wait_enable;
    logic wait_expired;
    logic apb_abort;

    assign cmd_ready    = (state_q == IDLE) && !preset;
    assign cmd_accept   = cmd_valid && cmd_ready;
    assign apb_complete = (state_q == ACCESS) && psel_q && penable_q && pready;
    assign wait_enable  = (state_q == ACCESS) && !pready;
    assign apb_abort    = wait_enable && wait_expired;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk_i      (pclk),
        .rst_i      (preset),
        .clear_i    (cmd_accept),
        .enable_i   (wait_enable),
        .terminal_o (wait_expired)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb_complete || apb_abort) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A completing pready takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pprot_d   = cmd_prot;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (apb_complete) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (apb_abort) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed bench for the APB4 bridge: write, waited read, slave error, watchdog abort,
// response backpressure and reset in the middle of an ACCESS phase.
module tb_apb4_master_bridge;
    import apb_pkg::*;

    localparam int ADDRWIDTH = 12;

    logic                 pclk;
    logic                 preset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;
    logic [3:0]           cmd_strb;
    logic [2:0]           cmd_prot;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [31:0]          pwdata;
    logic [3:0]           pstrb;
    logic [2:0]           pprot;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    int checks   = 0;
    int failures = 0;

    apb4_master_bridge #(
        .ADDRWIDTH      (ADDRWIDTH),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Advance one edge and settle just after it so registered outputs are stable.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [ADDRWIDTH-1:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_prot  = prot;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, " psel"},    32'(psel),    32'h0);
        checkOutput({tag, " penable"}, 32'(penable), 32'h0);
    endtask

    initial begin
        logic [2:0] nonsecProt;
        nonsecProt = '0;
        nonsecProt[PPROT_NONSEC] = 1'b1;

        preset    = 1'b1;
        rsp_ready = 1'b0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        applyStimulus(1'b1, 1'b1, 12'hFFF, 32'hFFFF_FFFF, 4'hF, 3'h7);

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'h0);
        checkIdleBus("reset");
        checkOutput("reset pwrite",      32'(pwrite),      32'h0);
        checkOutput("reset paddr",       32'(paddr),       32'h0);
        checkOutput("reset pwdata",      pwdata,           32'h0);
        checkOutput("reset pstrb",       32'(pstrb),       32'h0);
        checkOutput("reset pprot",       32'(pprot),       32'h0);
        checkOutput("reset rsp_valid",   32'(rsp_valid),   32'h0);
        checkOutput("reset rsp_err",     32'(rsp_err),     32'h0);
        checkOutput("reset rsp_timeout", 32'(rsp_timeout), 32'h0);
        checkOutput("reset rsp_rdata",   rsp_rdata,        32'h0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        preset = 1'b0;
        tick();
        checkOutput("idle cmd_ready", 32'(cmd_ready), 32'h1);

        $display("[TB] write, zero wait states");
        applyStimulus(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, nonsecProt);
        pready = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("wr setup psel",    32'(psel),      32'h1);
        checkOutput("wr setup penable", 32'(penable),   32'h0);
        checkOutput("wr setup paddr",   32'(paddr),     32'h010);
        checkOutput("wr setup pwrite",  32'(pwrite),    32'h1);
        checkOutput("wr setup pwdata",  pwdata,         32'hDEAD_BEEF);
        checkOutput("wr setup pstrb",   32'(pstrb),     32'hF);
        checkOutput("wr setup pprot",   32'(pprot),     32'h2);
        checkOutput("wr setup cmd_rdy", 32'(cmd_ready), 32'h0);
        tick();
        checkOutput("wr access psel",    32'(psel),      32'h1);
        checkOutput("wr access penable", 32'(penable),   32'h1);
        checkOutput("wr access rsp_vld", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("wr resp rsp_valid", 32'(rsp_valid), 32'h1);
        checkIdleBus("wr resp");
        checkOutput("wr resp rsp_err",   32'(rsp_err),   32'h0);
        checkOutput("wr resp rsp_tmo",   32'(rsp_timeout), 32'h0);
        checkOutput("wr resp rsp_rdata", rsp_rdata,      32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("wr done rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("wr done cmd_ready", 32'(cmd_ready), 32'h1);

        $display("[TB] read, three wait states (completes on the watchdog's last cycle)");
        pready = 1'b0;
        prdata = 32'hBAD0_BAD0;
        applyStimulus(1'b1, 1'b0, 12'h024, 32'h5555_5555, 4'hF, 3'h5);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("rd setup pstrb",  32'(pstrb),  32'h0);
        checkOutput("rd setup pwrite", 32'(pwrite), 32'h0);
        checkOutput("rd setup pwdata", pwdata,      32'hDEAD_BEEF);
        checkOutput("rd setup pprot",  32'(pprot),  32'h5);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("rd access%0d psel", i),    32'(psel),      32'h1);
            checkOutput($sformatf("rd access%0d penable", i), 32'(penable),   32'h1);
            checkOutput($sformatf("rd access%0d paddr", i),   32'(paddr),     32'h024);
            checkOutput($sformatf("rd access%0d pstrb", i),   32'(pstrb),     32'h0);
            checkOutput($sformatf("rd access%0d rsp_vld", i), 32'(rsp_valid), 32'h0);
        end
        pready = 1'b1;
        prdata = 32'h1234_5678;
        tick();
        checkOutput("rd resp rsp_valid", 32'(rsp_valid),   32'h1);
        checkOutput("rd resp rsp_rdata", rsp_rdata,        32'h1234_5678);
        checkOutput("rd resp rsp_err",   32'(rsp_err),     32'h0);
        checkOutput("rd resp rsp_tmo",   32'(rsp_timeout), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("[TB] write with slave error");
        pslverr = 1'b1;
        applyStimulus(1'b1, 1'b1, 12'h030, 32'hA5A5_A5A5, 4'h3, 3'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("err setup pstrb", 32'(pstrb), 32'h3);
        tick();
        checkOutput("err access penable", 32'(penable), 32'h1);
        tick();
        pslverr = 1'b0;
        checkOutput("err resp rsp_valid", 32'(rsp_valid),   32'h1);
        checkOutput("err resp rsp_err",   32'(rsp_err),     32'h1);
        checkOutput("err resp rsp_tmo",   32'(rsp_timeout), 32'h0);
        checkOutput("err resp rsp_rdata", rsp_rdata,        32'h0);
        checkIdleBus("err resp");
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("[TB] watchdog abort after four ACCESS cycles");
        pready = 1'b0;
        prdata = 32'hCAFE_F00D;
        applyStimulus(1'b1, 1'b0, 12'h040, 32'h0, 4'hF, 3'h1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("tmo access%0d penable", i), 32'(penable),   32'h1);
            checkOutput($sformatf("tmo access%0d rsp_vld", i), 32'(rsp_valid), 32'h0);
        end
        tick();
        checkIdleBus("tmo resp");
        checkOutput("tmo resp rsp_valid", 32'(rsp_valid),   32'h1);
        checkOutput("tmo resp rsp_err",   32'(rsp_err),     32'h1);
        checkOutput("tmo resp rsp_tmo",   32'(rsp_timeout), 32'h1);
        checkOutput("tmo resp rsp_rdata", rsp_rdata,        32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("[TB] response backpressure with a pending command");
        pready = 1'b1;
        applyStimulus(1'b1, 1'b1, 12'h044, 32'h1111_2222, 4'hF, 3'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 12'h050, 32'h3333_4444, 4'hC, 3'h0);
        tick();
        checkOutput("bp access paddr", 32'(paddr), 32'h044);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp hold%0d cmd_ready", i), 32'(cmd_ready), 32'h0);
            checkOutput($sformatf("bp hold%0d psel", i),      32'(psel),      32'h0);
            checkOutput($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'h1);
            checkOutput($sformatf("bp hold%0d rsp_err", i),   32'(rsp_err),   32'h0);
            checkOutput($sformatf("bp hold%0d rsp_tmo", i),   32'(rsp_timeout), 32'h0);
            checkOutput($sformatf("bp hold%0d paddr", i),     32'(paddr),     32'h044);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp still in resp", 32'(rsp_valid), 32'h1);
        tick();
        rsp_ready = 1'b0;
        checkOutput("bp idle rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("bp idle cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("bp idle psel",      32'(psel),      32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("bp second psel",   32'(psel),  32'h1);
        checkOutput("bp second paddr",  32'(paddr), 32'h050);
        checkOutput("bp second pwdata", pwdata,     32'h3333_4444);
        checkOutput("bp second pstrb",  32'(pstrb), 32'hC);
        tick();
        tick();
        checkOutput("bp second rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("[TB] reset during ACCESS wait states");
        pready = 1'b0;
        applyStimulus(1'b1, 1'b1, 12'h060, 32'h7777_8888, 4'hF, 3'h3);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        tick();
        checkOutput("rst pre penable", 32'(penable), 32'h1);
        preset = 1'b1;
        tick();
        checkIdleBus("rst mid");
        checkOutput("rst mid paddr",     32'(paddr),     32'h0);
        checkOutput("rst mid pwdata",    pwdata,         32'h0);
        checkOutput("rst mid pstrb",     32'(pstrb),     32'h0);
        checkOutput("rst mid pprot",     32'(pprot),     32'h0);
        checkOutput("rst mid pwrite",    32'(pwrite),    32'h0);
        checkOutput("rst mid rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst mid cmd_ready", 32'(cmd_ready), 32'h0);
        preset = 1'b0;
        pready = 1'b1;
        #1;
        checkOutput("rst post cmd_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst post%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
            checkOutput($sformatf("rst post%0d psel", i),      32'(psel),      32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- APB4 requester. Converts a simple valid/ready command stream into APB4 SETUP/ACCESS transfers on one APB4 slave port.
- Returns read data and error status on a valid/ready response stream.
- Sits between an internal control master (DMA, debug, CPU shim) and APB4 peripherals that present the standard slave-side register interface.
- One transfer outstanding at a time. Supports wait states (pready low), pslverr capture, and a bus timeout watchdog.

Parameters:
- ADDRWIDTH, 12: width of paddr and cmd_addr.
- TIMEOUT_CYCLES, 256: maximum ACCESS-phase cycles with pready low before abort. 0 disables the watchdog.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRWIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by watchdog.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDRWIDTH  APB address.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset (preset = 1 at a pclk edge):
  - State goes to IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0.
  - paddr, pwdata, pstrb, pprot and rsp_rdata are 0.
  - cmd_ready is 0 during reset.
- Reset mid-transfer drops psel/penable on the next edge. There is no response for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch the command into the APB output registers and go to SETUP.
  - Next cycle: psel = 1, penable = 0.
- Read strobes: pstrb is forced to 4'b0000 when cmd_write = 0 (APB4 rule). pwdata holds its previous value on reads.
- SETUP: lasts exactly one cycle. Next state is ACCESS with penable = 1 and psel = 1.
- ACCESS:
  - paddr, pwrite, pwdata, pstrb and pprot are held stable.
  - Wait counter increments each cycle that pready = 0.
  - On pready = 1: capture prdata (reads only; 0 for writes) and pslverr into rsp_rdata/rsp_err, set rsp_timeout = 0, drop psel/penable, go to RESP.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with pready still 0: drop psel/penable, set rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
  - pready and timeout in the same cycle: pready wins (normal completion).
- RESP:
  - rsp_valid = 1. Response fields are held stable until rsp_ready.
  - On rsp_ready go to IDLE and clear rsp_valid.
- Minimum latency: command accept to rsp_valid is 3 cycles with zero wait states (accept edge, SETUP, ACCESS).
- Back-to-back throughput is one command per 4 cycles, because IDLE re-entry is required.
- psel is never high in IDLE or RESP. penable is high only in ACCESS.
- Wait counter: width is clog2(TIMEOUT_CYCLES) + 1, minimum 1. It clears on entry to SETUP.
- pslverr is sampled only when psel & penable & pready, and ignored otherwise.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - APB_DATA_W = 32 and APB_STRB_W = 4;
  - the pprot bit-position constants (PRIV = 0, NONSEC = 1, INSTR = 2).
- One sub-module: apb_timeout_counter (enable, clear, terminal-count output, parameter TIMEOUT_CYCLES). It is reused by future APB interconnect blocks.

Test Plan:
- Write with zero waits: cmd write addr 0x010, wdata 0xDEADBEEF, strb 0xF.
  - Expect psel = 1, penable = 0 for 1 cycle, then psel = 1, penable = 1 with pready = 1.
  - Expect rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: addr 0x024, slave holds pready = 0 for 3 ACCESS cycles, then prdata = 0x12345678.
  - Expect pstrb = 0, paddr stable across all ACCESS cycles, rsp_rdata = 0x12345678.
- Slave error: write with pslverr = 1 at pready.
  - Expect rsp_err = 1, rsp_timeout = 0, and psel low the next cycle.
- Timeout: TIMEOUT_CYCLES = 4, pready stuck at 0.
  - Expect exactly 4 ACCESS cycles, then psel = 0, rsp_err = 1, rsp_timeout = 1.
  - Also pready = 1 on the 4th cycle must give normal completion.
- Response backpressure: hold rsp_ready = 0 for 5 cycles with a second cmd_valid pending.
  - Expect cmd_ready = 0, psel = 0, rsp fields stable.
  - After rsp_ready, the second command is accepted in IDLE the following cycle.
- Reset mid-ACCESS: assert preset during wait states.
  - Expect all outputs 0 next edge, cmd_ready = 1 after reset deasserts, and no spurious rsp_valid.
